// File: rtl/operand_fetch.sv
// Operand fetch: R stage (RF read in flight) feeding O stage (output register).
// Optional writeback bypass when OPF_BYPASS_EN is defined.
module operand_fetch #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6,
  parameter int SQN_W = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [TAG_W-1:0]            in_tagA,
  input  logic [TAG_W-1:0]            in_tagB,
  input  logic                        in_immB,
  input  logic [WIDTH-1:0]            in_imm,
  input  logic [SQN_W-1:0]            in_sqn,
  output logic                        in_ready,
  output logic [TAG_W-1:0]            rf_raddrA,
  output logic [TAG_W-1:0]            rf_raddrB,
  input  logic [WIDTH-1:0]            rf_rdataA,
  input  logic [WIDTH-1:0]            rf_rdataB,
  input  logic [2:0]                  wb_valid,
  input  logic [2:0][TAG_W-1:0]       wb_tag,
  input  logic [2:0][WIDTH-1:0]       wb_data,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_opA,
  output logic [WIDTH-1:0]            out_opB,
  output logic [SQN_W-1:0]            out_sqn,
  input  logic                        out_ready
);

  logic             r_rv;
  logic [TAG_W-1:0] r_tagA;
  logic [TAG_W-1:0] r_tagB;
  logic             r_immB;
  logic [WIDTH-1:0] r_imm;
  logic [SQN_W-1:0] r_sqn;
  logic             r_bvA;
  logic             r_bvB;
  logic [WIDTH-1:0] r_bA;
  logic [WIDTH-1:0] r_bB;
  logic             r_ov;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [SQN_W-1:0] r_osqn;

  logic             w_o_adv;
  logic             w_r_adv;
  logic             w_acc;
  logic             w_hitA;
  logic             w_hitB;
  logic [WIDTH-1:0] w_bypA;
  logic [WIDTH-1:0] w_bypB;
  logic [WIDTH-1:0] w_opA;
  logic [WIDTH-1:0] w_opB;

  assign w_o_adv  = !r_ov || out_ready;
  assign w_r_adv  = !r_rv || w_o_adv;
  assign in_ready = rst && w_r_adv && !flush;
  assign w_acc    = in_valid && in_ready;

  // A stalled uop keeps re-reading its own tags.
  assign rf_raddrA = (r_rv && !w_r_adv) ? r_tagA : in_tagA;
  assign rf_raddrB = (r_rv && !w_r_adv) ? r_tagB : in_tagB;

`ifdef OPF_BYPASS_EN
  // Scan high to low so the lowest port index wins.
  always_comb begin
    w_hitA = 1'b0;
    w_hitB = 1'b0;
    w_bypA = '0;
    w_bypB = '0;
    for (int i = 2; i >= 0; i--) begin
      if (wb_valid[i] && wb_tag[i] == rf_raddrA
          && rf_raddrA != '0) begin
        w_hitA = 1'b1;
        w_bypA = wb_data[i];
      end
      if (wb_valid[i] && wb_tag[i] == rf_raddrB
          && rf_raddrB != '0) begin
        w_hitB = 1'b1;
        w_bypB = wb_data[i];
      end
    end
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_valid, wb_tag, wb_data};
  assign w_hitA = 1'b0;
  assign w_hitB = 1'b0;
  assign w_bypA = '0;
  assign w_bypB = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rv   <= 1'b0;
      r_tagA <= '0;
      r_tagB <= '0;
      r_immB <= 1'b0;
      r_imm  <= '0;
      r_sqn  <= '0;
      r_bvA  <= 1'b0;
      r_bvB  <= 1'b0;
      r_bA   <= '0;
      r_bB   <= '0;
    end else if (flush) begin
      r_rv  <= 1'b0;
      r_bvA <= 1'b0;
      r_bvB <= 1'b0;
    end else if (w_r_adv) begin
      r_rv  <= w_acc;
      r_bvA <= w_acc && w_hitA;
      r_bvB <= w_acc && w_hitB;
      r_bA  <= w_bypA;
      r_bB  <= w_bypB;
      if (w_acc) begin
        r_tagA <= in_tagA;
        r_tagB <= in_tagB;
        r_immB <= in_immB;
        r_imm  <= in_imm;
        r_sqn  <= in_sqn;
      end
    end else begin
      if (w_hitA) begin
        r_bvA <= 1'b1;
        r_bA  <= w_bypA;
      end
      if (w_hitB) begin
        r_bvB <= 1'b1;
        r_bB  <= w_bypB;
      end
    end
  end

  assign w_opA = (r_tagA == '0) ? '0
               : r_bvA ? r_bA : rf_rdataA;
  assign w_opB = r_immB ? r_imm
               : (r_tagB == '0) ? '0
               : r_bvB ? r_bB : rf_rdataB;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ov   <= 1'b0;
      r_opA  <= '0;
      r_opB  <= '0;
      r_osqn <= '0;
    end else if (flush) begin
      r_ov <= 1'b0;
    end else if (w_o_adv) begin
      r_ov <= r_rv;
      if (r_rv) begin
        r_opA  <= w_opA;
        r_opB  <= w_opB;
        r_osqn <= r_sqn;
      end
    end
  end

  assign out_valid = r_ov;
  assign out_opA   = r_opA;
  assign out_opB   = r_opB;
  assign out_sqn   = r_osqn;

endmodule
